ex_commit: RTL and testbench

EX_COMMIT -- requirements
Module: ex_commit

---
 rtl/ex_commit_pkg.sv | 25 ++
 rtl/ex_commit_rr_arb.sv | 33 +++
 rtl/ex_commit.sv | 119 +++++++++++
 tb/tb_ex_commit.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_commit_pkg.sv
// Shared CPU definitions used by the commit stage: unit indices, register-number
// and data widths, and the round-robin pointer advance helper.
package ex_commit_pkg;

  localparam int XLEN    = 64;
  localparam int RN_W    = 6;
  localparam int N_UNITS = 3;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'd0,
    UNIT_MUL = 2'd1,
    UNIT_LSU = 2'd2
  } unit_e;

  // Pointer moves to the unit just after the one granted.
  function automatic unit_e next_ptr(input logic [N_UNITS-1:0] gnt, input unit_e cur);
    unit_e nxt;
    nxt = cur;
    if (gnt[UNIT_ALU]) nxt = UNIT_MUL;
    else if (gnt[UNIT_MUL]) nxt = UNIT_LSU;
    else if (gnt[UNIT_LSU]) nxt = UNIT_ALU;
    return nxt;
  endfunction

endpackage

// File: rtl/ex_commit_rr_arb.sv
// Three-way round-robin arbiter: priority starts at i_ptr and rotates upward,
// producing a one-hot (or all-zero) grant combinationally.
module ex_commit_rr_arb
  import ex_commit_pkg::*;
(
  input  logic [N_UNITS-1:0] i_req,
  input  unit_e              i_ptr,
  output logic [N_UNITS-1:0] o_gnt
);

  always_comb begin
    o_gnt = '0;
    case (i_ptr)
      UNIT_MUL: begin
        if (i_req[1])      o_gnt = 3'b010;
        else if (i_req[2]) o_gnt = 3'b100;
        else if (i_req[0]) o_gnt = 3'b001;
      end
      UNIT_LSU: begin
        if (i_req[2])      o_gnt = 3'b100;
        else if (i_req[0]) o_gnt = 3'b001;
        else if (i_req[1]) o_gnt = 3'b010;
      end
      // Unused encoding 3 falls back to ALU-first ordering.
      default: begin
        if (i_req[0])      o_gnt = 3'b001;
        else if (i_req[1]) o_gnt = 3'b010;
        else if (i_req[2]) o_gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/ex_commit.sv
// Commit stage: picks one execution-unit result per cycle, registers it as the
// register-file write and scoreboard clear. Optional RAISIN64_COMMIT_FWD_EN adds bypass outputs.
module ex_commit
  import ex_commit_pkg::*;
#(
  parameter bit ZERO_DISCARD = 1'b1,
  parameter int CNT_W        = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  alu_out,
  input  logic [RN_W-1:0]  alu_rd_rn,
  input  logic             alu_valid,
  input  logic [XLEN-1:0]  mul_out,
  input  logic [RN_W-1:0]  mul_rd_rn,
  input  logic             mul_valid,
  input  logic [XLEN-1:0]  lsu_out,
  input  logic [RN_W-1:0]  lsu_rd_rn,
  input  logic             lsu_valid,
  output logic             alu_stall,
  output logic             mul_stall,
  output logic             lsu_stall,
  output logic             rf_we,
  output logic [RN_W-1:0]  rf_wa,
  output logic [XLEN-1:0]  rf_wd,
  output logic             sb_clr,
  output logic [RN_W-1:0]  sb_clr_rn,
`ifdef RAISIN64_COMMIT_FWD_EN
  output logic             fwd_valid,
  output logic [RN_W-1:0]  fwd_rn,
  output logic [XLEN-1:0]  fwd_data,
`endif
  output logic [CNT_W-1:0] retired
);

  logic [N_UNITS-1:0] w_req;
  logic [N_UNITS-1:0] w_gnt;
  logic               w_vld_p0;
  logic [RN_W-1:0]    w_rn_p0;
  logic [XLEN-1:0]    w_data_p0;

  unit_e              r_ptr;
  logic               r_we_p1;
  logic [RN_W-1:0]    r_wa_p1;
  logic [XLEN-1:0]    r_wd_p1;
  logic               r_clr_p1;
  logic [RN_W-1:0]    r_clr_rn_p1;
  logic [CNT_W-1:0]   r_retired;

  assign w_req = {lsu_valid, mul_valid, alu_valid};

  ex_commit_rr_arb u_arb (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  // p0: grant select (combinational)
  always_comb begin
    w_vld_p0  = 1'b0;
    w_rn_p0   = '0;
    w_data_p0 = '0;
    if (w_gnt[UNIT_ALU]) begin
      w_vld_p0  = 1'b1;
      w_rn_p0   = alu_rd_rn;
      w_data_p0 = alu_out;
    end else if (w_gnt[UNIT_MUL]) begin
      w_vld_p0  = 1'b1;
      w_rn_p0   = mul_rd_rn;
      w_data_p0 = mul_out;
    end else if (w_gnt[UNIT_LSU]) begin
      w_vld_p0  = 1'b1;
      w_rn_p0   = lsu_rd_rn;
      w_data_p0 = lsu_out;
    end
  end

  assign alu_stall = alu_valid & ~w_gnt[UNIT_ALU];
  assign mul_stall = mul_valid & ~w_gnt[UNIT_MUL];
  assign lsu_stall = lsu_valid & ~w_gnt[UNIT_LSU];

  // p1: registered write, scoreboard clear and retire count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= UNIT_ALU;
      r_we_p1     <= 1'b0;
      r_wa_p1     <= '0;
      r_wd_p1     <= '0;
      r_clr_p1    <= 1'b0;
      r_clr_rn_p1 <= '0;
      r_retired   <= '0;
    end else begin
      // An r0 destination still retires and clears the scoreboard, but never writes.
      r_we_p1  <= w_vld_p0 && !(ZERO_DISCARD && (w_rn_p0 == '0));
      r_clr_p1 <= w_vld_p0;
      if (w_vld_p0) begin
        r_ptr       <= next_ptr(w_gnt, r_ptr);
        r_wa_p1     <= w_rn_p0;
        r_wd_p1     <= w_data_p0;
        r_clr_rn_p1 <= w_rn_p0;
        r_retired   <= r_retired + CNT_W'(1);
      end
    end
  end

  assign rf_we     = r_we_p1;
  assign rf_wa     = r_wa_p1;
  assign rf_wd     = r_wd_p1;
  assign sb_clr    = r_clr_p1;
  assign sb_clr_rn = r_clr_rn_p1;
  assign retired   = r_retired;

`ifdef RAISIN64_COMMIT_FWD_EN
  assign fwd_valid = w_vld_p0;
  assign fwd_rn    = w_rn_p0;
  assign fwd_data  = w_data_p0;
`endif

endmodule

// File: tb/tb_ex_commit.sv
// Self-checking bench for ex_commit: scoreboard of expected registered writes
// plus directed scenarios; a CNT_W=4 instance shares the stimulus for wrap checks.
module tb_ex_commit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [63:0] u_out [3];
  logic [5:0]  u_rd  [3];
  logic        u_vld [3];

  logic        alu_stall, mul_stall, lsu_stall;
  logic        rf_we, sb_clr;
  logic [5:0]  rf_wa, sb_clr_rn;
  logic [63:0] rf_wd, retired;

  logic        w4_alu_stall, w4_mul_stall, w4_lsu_stall;
  logic        w4_rf_we, w4_sb_clr;
  logic [5:0]  w4_rf_wa, w4_sb_clr_rn;
  logic [63:0] w4_rf_wd;
  logic [3:0]  w4_retired;

`ifdef RAISIN64_COMMIT_FWD_EN
  logic        fwd_valid, w4_fwd_valid;
  logic [5:0]  fwd_rn, w4_fwd_rn;
  logic [63:0] fwd_data, w4_fwd_data;
`endif

  ex_commit #(.ZERO_DISCARD(1'b1), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_out(u_out[0]), .alu_rd_rn(u_rd[0]), .alu_valid(u_vld[0]),
    .mul_out(u_out[1]), .mul_rd_rn(u_rd[1]), .mul_valid(u_vld[1]),
    .lsu_out(u_out[2]), .lsu_rd_rn(u_rd[2]), .lsu_valid(u_vld[2]),
    .alu_stall(alu_stall), .mul_stall(mul_stall), .lsu_stall(lsu_stall),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .sb_clr(sb_clr), .sb_clr_rn(sb_clr_rn),
`ifdef RAISIN64_COMMIT_FWD_EN
    .fwd_valid(fwd_valid), .fwd_rn(fwd_rn), .fwd_data(fwd_data),
`endif
    .retired(retired)
  );

  ex_commit #(.ZERO_DISCARD(1'b1), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .alu_out(u_out[0]), .alu_rd_rn(u_rd[0]), .alu_valid(u_vld[0]),
    .mul_out(u_out[1]), .mul_rd_rn(u_rd[1]), .mul_valid(u_vld[1]),
    .lsu_out(u_out[2]), .lsu_rd_rn(u_rd[2]), .lsu_valid(u_vld[2]),
    .alu_stall(w4_alu_stall), .mul_stall(w4_mul_stall), .lsu_stall(w4_lsu_stall),
    .rf_we(w4_rf_we), .rf_wa(w4_rf_wa), .rf_wd(w4_rf_wd),
    .sb_clr(w4_sb_clr), .sb_clr_rn(w4_sb_clr_rn),
`ifdef RAISIN64_COMMIT_FWD_EN
    .fwd_valid(w4_fwd_valid), .fwd_rn(w4_fwd_rn), .fwd_data(w4_fwd_data),
`endif
    .retired(w4_retired)
  );

  typedef struct packed {
    logic        we;
    logic [5:0]  wa;
    logic [63:0] wd;
    logic        clr;
    logic [5:0]  crn;
  } exp_t;

  exp_t        sbq[$];
  int          m_ptr;
  logic [63:0] m_retired;
  logic [5:0]  m_wa, m_crn;
  logic [63:0] m_wd;
  int          checks, failures;
  logic [2:0]  last_stall;

  task automatic idle_inputs();
    for (int u = 0; u < 3; u++) begin
      u_vld[u] = 1'b0;
      u_rd[u]  = '0;
      u_out[u] = '0;
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_retired = '0; m_wa = '0; m_wd = '0; m_crn = '0;
    sbq.delete();
  endtask

  // Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic commit_cycle();
    int         g;
    exp_t       e;
    logic [2:0] st_exp, st_act;
    g = -1;
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (m_ptr + k) % 3;
      if (g < 0 && u_vld[idx]) g = idx;
    end
    #1;
    st_act = {lsu_stall, mul_stall, alu_stall};
    for (int u = 0; u < 3; u++) st_exp[u] = u_vld[u] && (u != g);
    checks++;
    if (st_act !== st_exp) begin
      failures++;
      $display("FAIL stall {lsu,mul,alu} got=%b exp=%b", st_act, st_exp);
    end
    last_stall = st_act;
`ifdef RAISIN64_COMMIT_FWD_EN
    checks++;
    if (fwd_valid !== (g >= 0) || (g >= 0 && (fwd_rn !== u_rd[g] || fwd_data !== u_out[g]))) begin
      failures++;
      $display("FAIL fwd got v=%b rn=%0d d=%h grant=%0d", fwd_valid, fwd_rn, fwd_data, g);
    end
`endif
    if (g >= 0) begin
      m_wa = u_rd[g]; m_wd = u_out[g]; m_crn = u_rd[g];
      m_ptr = (g + 1) % 3;
      m_retired = m_retired + 64'd1;
      e.we  = (u_rd[g] != 6'd0);
      e.clr = 1'b1;
    end else begin
      e.we  = 1'b0;
      e.clr = 1'b0;
    end
    e.wa = m_wa; e.wd = m_wd; e.crn = m_crn;
    sbq.push_back(e);
    @(posedge clk); #1;
    e = sbq.pop_front();
    checks++;
    if (rf_we !== e.we || rf_wa !== e.wa || rf_wd !== e.wd) begin
      failures++;
      $display("FAIL rf_write got we=%b wa=%0d wd=%h exp we=%b wa=%0d wd=%h",
               rf_we, rf_wa, rf_wd, e.we, e.wa, e.wd);
    end
    checks++;
    if (sb_clr !== e.clr || sb_clr_rn !== e.crn) begin
      failures++;
      $display("FAIL sb_clr got clr=%b rn=%0d exp clr=%b rn=%0d", sb_clr, sb_clr_rn, e.clr, e.crn);
    end
    checks++;
    if (retired !== m_retired || w4_retired !== m_retired[3:0]) begin
      failures++;
      $display("FAIL retired got=%0d/%0d exp=%0d/%0d", retired, w4_retired, m_retired, m_retired[3:0]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rf_we, rf_wa, rf_wd, sb_clr, sb_clr_rn, retired, w4_retired} !== '0) begin
      failures++;
      $display("FAIL reset_state we=%b wa=%0d wd=%h clr=%b crn=%0d ret=%0d ret4=%0d",
               rf_we, rf_wa, rf_wd, sb_clr, sb_clr_rn, retired, w4_retired);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [63:0] base;
    base = m_retired;
    u_vld[0] = 1'b1; u_rd[0] = 6'd5; u_out[0] = 64'h1234;
    commit_cycle();
    checks++;
    if (rf_we !== 1'b1 || rf_wa !== 6'd5 || rf_wd !== 64'h1234 || last_stall[0] !== 1'b0 ||
        retired !== base + 64'd1) begin
      failures++;
      $display("FAIL single_alu got we=%b wa=%0d wd=%h stall=%b ret=%0d exp 1/5/1234/0/%0d",
               rf_we, rf_wa, rf_wd, last_stall[0], retired, base + 64'd1);
    end
    idle_inputs();
    commit_cycle();
    checks++;
    if (rf_we !== 1'b0 || rf_wa !== 6'd5 || rf_wd !== 64'h1234) begin
      failures++;
      $display("FAIL idle_hold got we=%b wa=%0d wd=%h exp 0/5/1234", rf_we, rf_wa, rf_wd);
    end
  endtask

  task automatic test_all_three();
    logic [63:0] base;
    logic [2:0]  exp_st [3];
    // Grant the LSU alone so the pointer returns to the ALU.
    idle_inputs();
    u_vld[2] = 1'b1; u_rd[2] = 6'd3; u_out[2] = 64'h33;
    commit_cycle();
    base = m_retired;
    exp_st[0] = 3'b110; exp_st[1] = 3'b100; exp_st[2] = 3'b000;
    for (int u = 0; u < 3; u++) begin
      u_vld[u] = 1'b1; u_rd[u] = 6'(10 + u); u_out[u] = 64'hA0 + 64'(u);
    end
    for (int c = 0; c < 3; c++) begin
      commit_cycle();
      checks++;
      if (last_stall !== exp_st[c] || rf_wa !== 6'(10 + c)) begin
        failures++;
        $display("FAIL all_three_c%0d stall=%b wa=%0d exp stall=%b wa=%0d",
                 c, last_stall, rf_wa, exp_st[c], 10 + c);
      end
      u_vld[c] = 1'b0;
    end
    checks++;
    if (retired !== base + 64'd3) begin
      failures++;
      $display("FAIL all_three_retired got=%0d exp=%0d", retired, base + 64'd3);
    end
    idle_inputs();
  endtask

  task automatic test_zero_discard();
    logic [63:0] base;
    base = m_retired;
    u_vld[0] = 1'b1; u_rd[0] = 6'd0; u_out[0] = 64'hDEAD;
    commit_cycle();
    checks++;
    if (rf_we !== 1'b0 || sb_clr !== 1'b1 || sb_clr_rn !== 6'd0 || retired !== base + 64'd1) begin
      failures++;
      $display("FAIL zero_discard got we=%b clr=%b crn=%0d ret=%0d exp 0/1/0/%0d",
               rf_we, sb_clr, sb_clr_rn, retired, base + 64'd1);
    end
    idle_inputs();
    commit_cycle();
  endtask

  task automatic test_random_rr();
    int waitc [3];
    for (int u = 0; u < 3; u++) waitc[u] = 0;
    idle_inputs();
    for (int c = 0; c < 80; c++) begin
      for (int u = 0; u < 3; u++) begin
        if (!u_vld[u] || !last_stall[u]) begin
          u_vld[u] = ($urandom_range(0, 3) != 0);
          u_rd[u]  = 6'($urandom_range(0, 63));
          u_out[u] = {$urandom, $urandom};
        end
      end
      commit_cycle();
      for (int u = 0; u < 3; u++) begin
        waitc[u] = last_stall[u] ? waitc[u] + 1 : 0;
        if (last_stall[u]) begin
          checks++;
          if (waitc[u] > 2) begin
            failures++;
            $display("FAIL starvation unit=%0d stalled=%0d exp<=2", u, waitc[u]);
          end
        end
      end
    end
    idle_inputs();
    commit_cycle();
  endtask

  task automatic test_mid_reset();
    u_vld[1] = 1'b1; u_rd[1] = 6'd7; u_out[1] = 64'h77;
    #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (rf_we !== 1'b0 || sb_clr !== 1'b0 || retired !== 64'd0) begin
      failures++;
      $display("FAIL mid_reset got we=%b clr=%b ret=%0d exp 0/0/0", rf_we, sb_clr, retired);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    checks++;
    if (rf_we !== 1'b0 || retired !== 64'd0) begin
      failures++;
      $display("FAIL post_release got we=%b ret=%0d exp 0/0", rf_we, retired);
    end
    @(posedge clk); #1;
    for (int u = 0; u < 3; u++) begin
      u_vld[u] = 1'b1; u_rd[u] = 6'(20 + u); u_out[u] = 64'hB0 + 64'(u);
    end
    commit_cycle();
    checks++;
    if (last_stall !== 3'b110 || rf_wa !== 6'd20) begin
      failures++;
      $display("FAIL ptr_after_reset stall=%b wa=%0d exp 110/20", last_stall, rf_wa);
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    int n;
    n = 0;
    u_vld[0] = 1'b1; u_rd[0] = 6'd1; u_out[0] = 64'h1;
    while (m_retired[3:0] != 4'd15 && n < 20) begin
      commit_cycle();
      n++;
    end
    checks++;
    if (w4_retired !== 4'd15) begin
      failures++;
      $display("FAIL wrap_pre got=%0d exp=15", w4_retired);
    end
    commit_cycle();
    checks++;
    if (w4_retired !== 4'd0) begin
      failures++;
      $display("FAIL wrap got=%0d exp=0", w4_retired);
    end
    idle_inputs();
  endtask

`ifdef RAISIN64_COMMIT_FWD_EN
  task automatic test_fwd();
    idle_inputs();
    u_vld[1] = 1'b1; u_rd[1] = 6'd9; u_out[1] = 64'hFF;
    #1;
    checks++;
    if (fwd_valid !== 1'b1 || fwd_rn !== 6'd9 || fwd_data !== 64'hFF) begin
      failures++;
      $display("FAIL fwd_mul got v=%b rn=%0d d=%h exp 1/9/ff", fwd_valid, fwd_rn, fwd_data);
    end
    commit_cycle();
    idle_inputs();
    #1;
    checks++;
    if (fwd_valid !== 1'b0 || fwd_rn !== 6'd0 || fwd_data !== 64'd0) begin
      failures++;
      $display("FAIL fwd_idle got v=%b rn=%0d d=%h exp 0/0/0", fwd_valid, fwd_rn, fwd_data);
    end
    commit_cycle();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; last_stall = '0;
    model_reset();
    test_reset();
    test_single();
    test_all_three();
    test_zero_discard();
    test_random_rr();
    test_mid_reset();
    test_wrap();
`ifdef RAISIN64_COMMIT_FWD_EN
    test_fwd();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
